// File: rtl/load_store_unit_pkg.sv
// Shared core definitions for the load/store unit:
// register-select codes, access widths and FSM states.
package load_store_unit_pkg;

  localparam logic [1:0] RD_SEL_MEM = 2'd1;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Width 3 is reserved and behaves as a word.
  function automatic logic is_misaligned(
    input logic [1:0] width,
    input logic [1:0] off
  );
    logic mis;
    unique case (width)
      WIDTH_BYTE: mis = 1'b0;
      WIDTH_HALF: mis = off[0];
      default:    mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load lane extraction: shift the word down to the
// accessed byte, truncate to width, then extend.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  width_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  // Align, truncate and extend the returned word
  always_comb begin
    sh = rdata_i >> {offset_i, 3'b000};
    unique case (width_i)
      WIDTH_BYTE: data_o = {{24{sign_i & sh[7]}}, sh[7:0]};
      WIDTH_HALF: data_o = {{16{sign_i & sh[15]}}, sh[15:0]};
      default:    data_o = sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEMPREP-stage load/store unit: one outstanding
// request, registered bus, stalls the pipe until done.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        invalid_MEMPREP,
  input  logic [31:0] alu_result_MEMPREP,
  input  logic        lsu_we_MEMPREP,
  input  logic        lsu_sign_extend_MEMPREP,
  input  logic [1:0]  data_width_MEMPREP,
  input  logic [1:0]  rd_data_sel_MEMPREP,
  input  logic [31:0] rs2_data_MEMPREP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data_MEMPREP,
  output logic        lsu_done,
  output logic        stall_MEMPREP,
  output logic        misaligned_fault
);

  lsu_state_t  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  width_q, width_d;
  logic        sign_q, sign_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] ld_q, ld_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  logic        access;
  logic        misaligned;
  logic [1:0]  off_in;
  logic [3:0]  be_st;
  logic [31:0] wdata_st;
  logic [31:0] ext_data;

  assign off_in = alu_result_MEMPREP[1:0];
  assign access = !invalid_MEMPREP &&
                  (lsu_we_MEMPREP ||
                   rd_data_sel_MEMPREP == RD_SEL_MEM);
  assign misaligned =
    is_misaligned(data_width_MEMPREP, off_in);

  // Store lane replication and byte enables
  always_comb begin
    be_st    = 4'b1111;
    wdata_st = rs2_data_MEMPREP;
    unique case (data_width_MEMPREP)
      WIDTH_BYTE: begin
        be_st    = 4'b0001 << off_in;
        wdata_st = {4{rs2_data_MEMPREP[7:0]}};
      end
      WIDTH_HALF: begin
        be_st    = 4'b0011 << {off_in[1], 1'b0};
        wdata_st = {2{rs2_data_MEMPREP[15:0]}};
      end
      default: begin
        be_st    = 4'b1111;
        wdata_st = rs2_data_MEMPREP;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata_i  (mem_rdata),
    .offset_i (off_q),
    .width_i  (width_q),
    .sign_i   (sign_q),
    .data_o   (ext_data)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    width_d = width_q;
    sign_d  = sign_q;
    off_d   = off_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && misaligned) begin
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else if (access) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = lsu_we_MEMPREP;
          addr_d  = {alu_result_MEMPREP[31:2], 2'b00};
          be_d    = lsu_we_MEMPREP ? be_st : 4'b1111;
          wdata_d = wdata_st;
          width_d = data_width_MEMPREP;
          sign_d  = lsu_sign_extend_MEMPREP;
          off_d   = off_in;
        end
      end
      REQ: begin
        req_d = 1'b1;
        if (mem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : WAIT;
          done_d  = we_q;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          ld_d    = ext_data;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bus registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      width_q <= '0;
      sign_q  <= 1'b0;
      off_q   <= '0;
      ld_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      sign_q  <= sign_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req           = req_q;
  assign mem_we            = we_q;
  assign mem_addr          = addr_q;
  assign mem_be            = be_q;
  assign mem_wdata         = wdata_q;
  assign load_data_MEMPREP = ld_q;
  assign lsu_done          = done_q;
  assign misaligned_fault  = fault_q;

  assign stall_MEMPREP =
    (state_q == IDLE && access && !misaligned) ||
    state_q == REQ || state_q == WAIT;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a
// byte-level reference model and per-cycle compare.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        invalid_MEMPREP;
  logic [31:0] alu_result_MEMPREP;
  logic        lsu_we_MEMPREP;
  logic        lsu_sign_extend_MEMPREP;
  logic [1:0]  data_width_MEMPREP;
  logic [1:0]  rd_data_sel_MEMPREP;
  logic [31:0] rs2_data_MEMPREP;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] load_data_MEMPREP;
  logic        lsu_done;
  logic        stall_MEMPREP;
  logic        misaligned_fault;

  int n_chk  = 0;
  int n_fail = 0;

  logic        chk_en   = 1'b0;
  logic        m_active = 1'b0;
  logic        m_we     = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wd     = '0;
  logic [31:0] m_ld     = '0;
  logic [3:0]  m_be     = '0;

  load_store_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .invalid_MEMPREP         (invalid_MEMPREP),
    .alu_result_MEMPREP      (alu_result_MEMPREP),
    .lsu_we_MEMPREP          (lsu_we_MEMPREP),
    .lsu_sign_extend_MEMPREP (lsu_sign_extend_MEMPREP),
    .data_width_MEMPREP      (data_width_MEMPREP),
    .rd_data_sel_MEMPREP     (rd_data_sel_MEMPREP),
    .rs2_data_MEMPREP        (rs2_data_MEMPREP),
    .mem_req                 (mem_req),
    .mem_we                  (mem_we),
    .mem_addr                (mem_addr),
    .mem_be                  (mem_be),
    .mem_wdata               (mem_wdata),
    .mem_gnt                 (mem_gnt),
    .mem_rvalid              (mem_rvalid),
    .mem_rdata               (mem_rdata),
    .load_data_MEMPREP       (load_data_MEMPREP),
    .lsu_done                (lsu_done),
    .stall_MEMPREP           (stall_MEMPREP),
    .misaligned_fault        (misaligned_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic int sz(input logic [1:0] w);
    if (w == WIDTH_BYTE) return 1;
    if (w == WIDTH_HALF) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(
    input logic [1:0] w, input logic [31:0] a);
    logic [3:0] be;
    int s;
    int o;
    s  = sz(w);
    o  = int'(a % 4);
    be = '0;
    for (int i = 0; i < 4; i++)
      be[i] = (i >= o) && (i < o + s);
    return be;
  endfunction

  function automatic logic [31:0] model_wd(
    input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    int s;
    s = sz(w);
    r = '0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = d[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_ld(
    input logic [31:0] rd, input logic [1:0] w,
    input logic [31:0] a, input logic sg);
    logic [63:0] val;
    logic [63:0] lim;
    int s;
    int o;
    s   = sz(w);
    o   = int'(a % 4);
    val = '0;
    for (int i = 0; i < s; i++)
      val = val + (64'(rd[8*(o+i) +: 8]) << (8*i));
    lim = 64'd1 << (8*s - 1);
    if (sg && val >= lim)
      val = val - (lim << 1);
    return val[31:0];
  endfunction

  task automatic bubble();
    invalid_MEMPREP         = 1'b1;
    alu_result_MEMPREP      = '0;
    lsu_we_MEMPREP          = 1'b0;
    lsu_sign_extend_MEMPREP = 1'b0;
    data_width_MEMPREP      = WIDTH_BYTE;
    rd_data_sel_MEMPREP     = 2'd0;
    rs2_data_MEMPREP        = '0;
  endtask

  task automatic present(input logic we,
                         input logic sg,
                         input logic [1:0] w,
                         input logic [31:0] a,
                         input logic [31:0] d);
    invalid_MEMPREP         = 1'b0;
    alu_result_MEMPREP      = a;
    lsu_we_MEMPREP          = we;
    lsu_sign_extend_MEMPREP = sg;
    data_width_MEMPREP      = w;
    rd_data_sel_MEMPREP     = we ? 2'd0 : RD_SEL_MEM;
    rs2_data_MEMPREP        = d;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("load_data", load_data_MEMPREP, m_ld);
      if (!m_active)
        check("idle_req", 32'(mem_req), 32'd0);
      else if (mem_req) begin
        check("bus_addr", mem_addr, m_addr);
        check("bus_be", 32'(mem_be), 32'(m_be));
        check("bus_we", 32'(mem_we), 32'(m_we));
        if (m_we)
          check("bus_wdata", mem_wdata, m_wd);
      end
    end
  end

  task automatic run_op(input logic we,
                        input logic sg,
                        input logic [1:0] w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [31:0] rd,
                        input int gd,
                        input int rv,
                        input logic noise,
                        input logic [3:0] lit_be,
                        input logic [31:0] lit);
    int rq;
    int wt;
    int done_at;
    logic granted;
    logic fire;
    logic [3:0]  f_be;
    logic [31:0] f_wd;
    m_addr = a & ~32'h3;
    m_we   = we;
    m_be   = we ? model_be(w, a) : 4'hF;
    m_wd   = model_wd(w, d);
    present(we, sg, w, a, d);
    m_active   = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check("stall_present", 32'(stall_MEMPREP), 32'd1);
    rq = 0; wt = 0; done_at = -1;
    granted = 1'b0; fire = 1'b0;
    f_be = '0; f_wd = '0;
    for (int n = 1; n <= 60 && done_at < 0; n++) begin
      @(posedge clk); #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (fire) begin
        m_ld = model_ld(rd, w, a, sg);
        fire = 1'b0;
      end
      if (lsu_done) begin
        done_at = n;
        check("stall_done", 32'(stall_MEMPREP), 32'd0);
        check("fault_done", 32'(misaligned_fault), 32'd0);
      end else if (mem_req) begin
        if (rq == 0) begin
          f_be = mem_be;
          f_wd = mem_wdata;
        end
        check("stall_req", 32'(stall_MEMPREP), 32'd1);
        if (noise) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hBAD0BAD0;
        end
        if (rq >= gd) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
        end
        rq++;
      end else if (granted && !we) begin
        check("stall_wait", 32'(stall_MEMPREP), 32'd1);
        if (wt >= rv) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd;
          fire       = 1'b1;
        end
        wt++;
      end
    end
    check("latency", 32'(done_at),
          32'(we ? 2 + gd : 3 + gd + rv));
    check("req_cycles", 32'(rq), 32'(gd + 1));
    check("lit_be", 32'(f_be), 32'(lit_be));
    if (we)
      check("lit_wdata", f_wd, lit);
    else
      check("lit_load", load_data_MEMPREP, lit);
    bubble();
    m_active = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", 32'(lsu_done), 32'd0);
  endtask

  task automatic misaligned(input logic we,
                            input logic [1:0] w,
                            input logic [31:0] a);
    present(we, 1'b0, w, a, 32'h12345678);
    #1;
    check("mis_stall", 32'(stall_MEMPREP), 32'd0);
    @(posedge clk); #1;
    check("mis_fault", 32'(misaligned_fault), 32'd1);
    check("mis_done", 32'(lsu_done), 32'd1);
    bubble();
    @(posedge clk); #1;
    check("mis_fault_end", 32'(misaligned_fault), 32'd0);
    check("mis_done_end", 32'(lsu_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    bubble();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ld", load_data_MEMPREP, 32'd0);
    check("rst_done", 32'(lsu_done), 32'd0);
    check("rst_fault", 32'(misaligned_fault), 32'd0);
    check("rst_stall", 32'(stall_MEMPREP), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_op(1, 0, WIDTH_BYTE, 32'h103, 32'hAABBCCDD,
           0, 0, 0, 0, 4'b1000, 32'hDDDDDDDD);
    run_op(0, 1, WIDTH_HALF, 32'h202, 0,
           32'h80011234, 0, 0, 0, 4'hF, 32'hFFFF8001);
    run_op(0, 0, WIDTH_HALF, 32'h202, 0,
           32'h80011234, 0, 0, 0, 4'hF, 32'h00008001);
    run_op(1, 0, WIDTH_HALF, 32'h12, 32'h12345678,
           0, 5, 0, 0, 4'b1100, 32'h56785678);
    run_op(1, 1, WIDTH_WORD, 32'h400, 32'hCAFEF00D,
           0, 1, 0, 0, 4'hF, 32'hCAFEF00D);
    run_op(0, 1, WIDTH_BYTE, 32'h501, 0,
           32'h11228344, 0, 0, 1, 4'hF, 32'hFFFFFF83);
    run_op(0, 0, WIDTH_BYTE, 32'h503, 0,
           32'h9A000000, 1, 2, 0, 4'hF, 32'h0000009A);
    run_op(0, 1, WIDTH_WORD, 32'h600, 0,
           32'h89ABCDEF, 2, 3, 1, 4'hF, 32'h89ABCDEF);
    run_op(0, 1, 2'd3, 32'h704, 0,
           32'h13579BDF, 0, 1, 0, 4'hF, 32'h13579BDF);
    run_op(1, 0, WIDTH_BYTE, 32'h100, 32'h00000055,
           0, 0, 0, 0, 4'b0001, 32'h55555555);

    misaligned(0, WIDTH_WORD, 32'h301);
    misaligned(1, WIDTH_HALF, 32'h205);

    present(1, 0, WIDTH_WORD, 32'h900, 32'h1);
    invalid_MEMPREP = 1'b1;
    #1;
    check("inv_stall", 32'(stall_MEMPREP), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("inv_done", 32'(lsu_done), 32'd0);
      check("inv_stall2", 32'(stall_MEMPREP), 32'd0);
    end
    bubble();

    m_addr = 32'h800; m_we = 1'b0; m_be = 4'hF;
    m_wd = '0;
    present(0, 0, WIDTH_WORD, 32'h800, 0);
    m_active = 1'b1;
    @(posedge clk); #1;
    check("rw_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("rw_wait_stall", 32'(stall_MEMPREP), 32'd1);
    check("rw_wait_req", 32'(mem_req), 32'd0);
    rst = 1'b1;
    bubble();
    @(posedge clk); #1;
    rst      = 1'b0;
    m_ld     = '0;
    m_active = 1'b0;
    check("rw_ld", load_data_MEMPREP, 32'd0);
    check("rw_done", 32'(lsu_done), 32'd0);
    check("rw_be", 32'(mem_be), 32'd0);
    check("rw_addr", mem_addr, 32'd0);
    check("rw_stall", 32'(stall_MEMPREP), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("rw_ld_late", load_data_MEMPREP, 32'd0);
    check("rw_done_late", 32'(lsu_done), 32'd0);
    check("rw_stall_late", 32'(stall_MEMPREP), 32'd0);
    @(posedge clk); #1;
    check("rw_done_late2", 32'(lsu_done), 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
